// File: rtl/tetris_pkg.sv
// Shared tetromino encodings, rot=0 block offsets and playfield defaults.
// Offset entries are packed {dx[2:0], dy[2:0]} in two's complement, block 3 leftmost.
package tetris_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  localparam logic [2:0] PIECE_O   = 3'd0;
  localparam logic [2:0] PIECE_I   = 3'd1;
  localparam logic [2:0] PIECE_T   = 3'd2;
  localparam logic [2:0] PIECE_S   = 3'd3;
  localparam logic [2:0] PIECE_Z   = 3'd4;
  localparam logic [2:0] PIECE_J   = 3'd5;
  localparam logic [2:0] PIECE_L   = 3'd6;
  localparam logic [2:0] PIECE_BAD = 3'd7;

  localparam logic [2:0] P0 = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b010;
  localparam logic [2:0] M1 = 3'b111;

  localparam logic [3:0][5:0] OFS_O = {P1, P0, P1, P1, P0, P1, P0, P0};
  localparam logic [3:0][5:0] OFS_I = {P2, P0, P1, P0, M1, P0, P0, P0};
  localparam logic [3:0][5:0] OFS_T = {P0, P1, P1, P0, M1, P0, P0, P0};
  localparam logic [3:0][5:0] OFS_S = {P1, P1, P0, P1, M1, P0, P0, P0};
  localparam logic [3:0][5:0] OFS_Z = {M1, P1, P0, P1, P1, P0, P0, P0};
  localparam logic [3:0][5:0] OFS_J = {M1, P1, P1, P0, M1, P0, P0, P0};
  localparam logic [3:0][5:0] OFS_L = {P1, P1, P1, P0, M1, P0, P0, P0};

  // The illegal type borrows the O shape so the index space is fully populated.
  localparam logic [7:0][3:0][5:0] OFS_TBL =
    {OFS_O, OFS_L, OFS_J, OFS_Z, OFS_S, OFS_T, OFS_I, OFS_O};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } gen_state_t;

endpackage

// File: rtl/piece_block_gen_if.sv
// Request / result handshake bundle between the piece controller and the block generator.
interface piece_block_gen_if #(
  parameter int X_W = 4,
  parameter int Y_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_type;
  logic [1:0]       req_rot;
  logic [X_W-1:0]   req_x;
  logic [Y_W-1:0]   req_y;
  logic             out_valid;
  logic             out_ready;
  logic [4*X_W-1:0] blk_x;
  logic [4*Y_W-1:0] blk_y;
  logic             out_wall;
  logic             out_floor;
  logic             out_top;
  logic             out_bad_type;

  modport master (
    output req_valid, req_type, req_rot, req_x, req_y, out_ready,
    input  req_ready, out_valid, blk_x, blk_y, out_wall, out_floor, out_top, out_bad_type
  );

  modport slave (
    input  req_valid, req_type, req_rot, req_x, req_y, out_ready,
    output req_ready, out_valid, blk_x, blk_y, out_wall, out_floor, out_top, out_bad_type
  );
endinterface

// File: rtl/piece_offset_rom.sv
// Combinational (type, rot, idx) -> signed block offset, rotation applied.
// O and the illegal type are rotation-invariant.
module piece_offset_rom
  import tetris_pkg::*;
(
  input  logic [2:0]        i_type,
  input  logic [1:0]        i_rot,
  input  logic [1:0]        i_idx,
  output logic signed [2:0] o_dx,
  output logic signed [2:0] o_dy
);

  logic [5:0]        w_entry;
  logic signed [2:0] w_bx;
  logic signed [2:0] w_by;
  logic [1:0]        w_rot;

  assign w_entry = OFS_TBL[i_type][i_idx];
  assign w_bx    = signed'(w_entry[5:3]);
  assign w_by    = signed'(w_entry[2:0]);
  assign w_rot   = ((i_type == PIECE_O) || (i_type == PIECE_BAD)) ? 2'd0 : i_rot;

  always_comb begin
    o_dx = w_bx;
    o_dy = w_by;
    case (w_rot)
      2'd1: begin o_dx = w_by;  o_dy = -w_bx; end
      2'd2: begin o_dx = -w_bx; o_dy = -w_by; end
      2'd3: begin o_dx = -w_by; o_dy = w_bx;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/piece_block_gen.sv
// Sequential tetromino block generator: resolves one block per cycle through the
// shared offset ROM and reports wall/floor/top/illegal-type flags.
module piece_block_gen
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int X_W     = 4,
  parameter int Y_W     = 5
) (
  input  logic              clk,
  input  logic              resetn,
  piece_block_gen_if.slave  bus
);

  localparam logic signed [X_W:0] W_LIM = (X_W+1)'(BOARD_W);
  localparam logic signed [Y_W:0] H_LIM = (Y_W+1)'(BOARD_H);

  gen_state_t r_state;
  gen_state_t w_state_nxt;

  logic [2:0]       r_type;
  logic [1:0]       r_rot;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [1:0]       r_idx;
  logic [4*X_W-1:0] r_blk_x;
  logic [4*Y_W-1:0] r_blk_y;
  logic             r_wall;
  logic             r_floor;
  logic             r_top;
  logic             r_bad;

  logic signed [2:0]   w_dx;
  logic signed [2:0]   w_dy;
  logic signed [X_W:0] w_sx;
  logic signed [Y_W:0] w_sy;
  logic                w_wall;
  logic                w_floor;
  logic                w_top;

  piece_offset_rom u_rom (
    .i_type (r_type),
    .i_rot  (r_rot),
    .i_idx  (r_idx),
    .o_dx   (w_dx),
    .o_dy   (w_dy)
  );

  // One extra bit of headroom so out-of-field sums keep their sign.
  assign w_sx    = signed'({1'b0, r_x}) + (X_W+1)'(w_dx);
  assign w_sy    = signed'({1'b0, r_y}) + (Y_W+1)'(w_dy);
  assign w_wall  = w_sx[X_W] || (w_sx >= W_LIM);
  assign w_floor = w_sy[Y_W];
  assign w_top   = (w_sy >= H_LIM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.req_valid)  w_state_nxt = ST_GEN;
      ST_GEN:  if (r_idx == 2'd3)  w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_type  <= '0;
      r_rot   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_blk_x <= '0;
      r_blk_y <= '0;
      r_wall  <= 1'b0;
      r_floor <= 1'b0;
      r_top   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_type  <= bus.req_type;
            r_rot   <= bus.req_rot;
            r_x     <= bus.req_x;
            r_y     <= bus.req_y;
            r_idx   <= 2'd0;
            r_wall  <= 1'b0;
            r_floor <= 1'b0;
            r_top   <= 1'b0;
            r_bad   <= 1'b0;
          end
        end
        ST_GEN: begin
          for (int k = 0; k < 4; k++) begin
            if (r_idx == 2'(k)) begin
              r_blk_x[k*X_W +: X_W] <= w_sx[X_W-1:0];
              r_blk_y[k*Y_W +: Y_W] <= w_sy[Y_W-1:0];
            end
          end
          r_wall  <= r_wall  | w_wall;
          r_floor <= r_floor | w_floor;
          r_top   <= r_top   | w_top;
          r_bad   <= r_bad   | (r_type == PIECE_BAD);
          r_idx   <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (r_state == ST_IDLE);
  assign bus.out_valid    = (r_state == ST_DONE);
  assign bus.blk_x        = r_blk_x;
  assign bus.blk_y        = r_blk_y;
  assign bus.out_wall     = r_wall;
  assign bus.out_floor    = r_floor;
  assign bus.out_top      = r_top;
  assign bus.out_bad_type = r_bad;

endmodule

// File: tb/tb_piece_block_gen.sv
// Scoreboard bench for piece_block_gen: expected block sets are queued at request time
// and compared when the result is delivered.
module tb_piece_block_gen;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [15:0] bx;
    logic [19:0] by;
    logic [3:0]  fl;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  piece_block_gen_if #(.X_W(4), .Y_W(5)) bus ();

  piece_block_gen #(.BOARD_W(10), .BOARD_H(20), .X_W(4), .Y_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  function automatic logic [3:0] obs_flags();
    return {bus.out_wall, bus.out_floor, bus.out_top, bus.out_bad_type};
  endfunction

  function automatic exp_t mk(input int x0, y0, x1, y1, x2, y2, x3, y3, input logic [3:0] fl);
    exp_t e;
    int xs[4];
    int ys[4];
    xs = '{x0, x1, x2, x3};
    ys = '{y0, y1, y2, y3};
    for (int k = 0; k < 4; k++) begin
      e.bx[k*4 +: 4] = xs[k][3:0];
      e.by[k*5 +: 5] = ys[k][4:0];
    end
    e.fl = fl;
    return e;
  endfunction

  // Reference: rot=0 shape, then repeated clockwise quarter-turns (x,y)->(y,-x).
  function automatic exp_t model(input int t, r, x, y);
    int ox[4];
    int oy[4];
    int px, py, tmp, rr, sx, sy;
    exp_t e;
    case (t)
      1: begin ox = '{0, -1, 1, 2};  oy = '{0, 0, 0, 0}; end
      2: begin ox = '{0, -1, 1, 0};  oy = '{0, 0, 0, 1}; end
      3: begin ox = '{0, -1, 0, 1};  oy = '{0, 0, 1, 1}; end
      4: begin ox = '{0, 1, 0, -1};  oy = '{0, 0, 1, 1}; end
      5: begin ox = '{0, -1, 1, -1}; oy = '{0, 0, 0, 1}; end
      6: begin ox = '{0, -1, 1, 1};  oy = '{0, 0, 0, 1}; end
      default: begin ox = '{0, 0, 1, 1}; oy = '{0, 1, 1, 0}; end
    endcase
    rr = (t == 0 || t == 7) ? 0 : r;
    e.fl = {3'b000, (t == 7)};
    for (int k = 0; k < 4; k++) begin
      px = ox[k];
      py = oy[k];
      for (int j = 0; j < rr; j++) begin
        tmp = px;
        px  = py;
        py  = -tmp;
      end
      sx = x + px;
      sy = y + py;
      if (sx < 0 || sx >= 10) e.fl[3] = 1'b1;
      if (sy < 0)             e.fl[2] = 1'b1;
      if (sy >= 20)           e.fl[1] = 1'b1;
      e.bx[k*4 +: 4] = sx[3:0];
      e.by[k*5 +: 5] = sy[4:0];
    end
    return e;
  endfunction

  task automatic send(input int t, r, x, y, input bit push, input exp_t e);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (bus.req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_ready req_ready=%b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_type  = 3'(t);
    bus.req_rot   = 2'(r);
    bus.req_x     = 4'(x);
    bus.req_y     = 5'(y);
    if (push) q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic receive(input string name);
    exp_t e;
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid out_valid=%b want 1", name, bus.out_valid);
    end else if (q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue result with empty scoreboard got=0 want=1", name);
    end else begin
      e = q.pop_front();
      checks++;
      if (bus.blk_x !== e.bx) begin
        errors++; $display("FAIL %s_blk_x got=%h want=%h", name, bus.blk_x, e.bx);
      end
      checks++;
      if (bus.blk_y !== e.by) begin
        errors++; $display("FAIL %s_blk_y got=%h want=%h", name, bus.blk_y, e.by);
      end
      checks++;
      if (obs_flags() !== e.fl) begin
        errors++; $display("FAIL %s_flags wall/floor/top/bad got=%b want=%b", name, obs_flags(), e.fl);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s_release valid/ready got=%b%b want=01", name, bus.out_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.blk_x !== 16'h0 ||
        bus.blk_y !== 20'h0 || obs_flags() !== 4'h0) begin
      errors++;
      $display("FAIL reset_state rdy=%b val=%b bx=%h by=%h fl=%b want 1 0 0 0 0",
               bus.req_ready, bus.out_valid, bus.blk_x, bus.blk_y, obs_flags());
    end
  endtask

  task automatic test_t_rot0_latency();
    send(2, 0, 5, 10, 1'b1, mk(5, 10, 4, 10, 6, 10, 5, 11, 4'b0000));
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early out_valid=%b want 0 in 4th cycle", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL latency_5th out_valid=%b want 1 in 5th cycle", bus.out_valid);
    end
    receive("t_rot0");
  endtask

  task automatic test_rotations();
    send(2, 1, 5, 10, 1'b1, mk(5, 10, 5, 11, 5, 9, 6, 10, 4'b0000));
    receive("t_rot1");
    send(2, 2, 5, 10, 1'b1, mk(5, 10, 6, 10, 4, 10, 5, 9, 4'b0000));
    receive("t_rot2");
  endtask

  task automatic test_bounds();
    send(1, 0, 8, 3, 1'b1, mk(8, 3, 7, 3, 9, 3, 10, 3, 4'b1000));
    receive("i_right_wall");
    send(1, 0, 0, 3, 1'b1, mk(0, 3, 15, 3, 1, 3, 2, 3, 4'b1000));
    receive("i_left_wall");
    send(5, 2, 4, 0, 1'b1, mk(4, 0, 5, 0, 3, 0, 5, 31, 4'b0100));
    receive("j_floor");
    send(0, 2, 3, 19, 1'b1, mk(3, 19, 3, 20, 4, 20, 4, 19, 4'b0010));
    receive("o_top");
  endtask

  task automatic test_bad_type_hold();
    exp_t e;
    int bad = 0;
    e = mk(2, 2, 2, 3, 3, 3, 3, 2, 4'b0001);
    send(7, 3, 2, 2, 1'b1, e);
    repeat (4) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_type  = 3'd1;
    bus.req_rot   = 2'd1;
    bus.req_x     = 4'd7;
    bus.req_y     = 5'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.blk_x !== e.bx ||
          bus.blk_y !== e.by || obs_flags() !== e.fl) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable unstable_cycles=%0d want 0", bad);
    end
    bus.req_valid = 1'b0;
    receive("bad_type");
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL ignored_req spurious_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_reset_mid_gen();
    send(1, 0, 0, 3, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.blk_x !== 16'h0 ||
        bus.blk_y !== 20'h0 || obs_flags() !== 4'h0) begin
      errors++;
      $display("FAIL reset_abort val=%b rdy=%b bx=%h by=%h fl=%b want 0 1 0 0 0",
               bus.out_valid, bus.req_ready, bus.blk_x, bus.blk_y, obs_flags());
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    send(2, 0, 5, 10, 1'b1, mk(5, 10, 4, 10, 6, 10, 5, 11, 4'b0000));
    receive("after_reset");
  endtask

  task automatic test_back_to_back();
    int t, r, x, y;
    for (int i = 0; i < 12; i++) begin
      t = $urandom_range(0, 7);
      r = $urandom_range(0, 3);
      x = $urandom_range(0, 12);
      y = $urandom_range(0, 28);
      send(t, r, x, y, 1'b1, model(t, r, x, y));
      receive("sweep");
    end
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_type  = 3'd0;
    bus.req_rot   = 2'd0;
    bus.req_x     = 4'd0;
    bus.req_y     = 5'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    @(negedge clk);
    test_t_rot0_latency();
    test_rotations();
    test_bounds();
    test_bad_type_hold();
    test_reset_mid_gen();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
